// File: rtl/encoder4_to2_queue.sv
// Sequential 4-to-2 encoder: captures request pulses into a pending register and
// emits them one at a time as {W1,W0}, highest index first, under valid/ready.
module encoder4_to2_queue (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic [3:0] q,
    input  logic       ready,
    output logic       W0,
    output logic       W1,
    output logic       valid,
    output logic [3:0] pending,
    output logic       overflow
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state_q, state_d;
    logic [3:0] p_q, p_d;
    logic [1:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       overflow_q, overflow_d;

    logic [3:0] set_term;
    logic [3:0] clr_term;
    logic [1:0] top_idx;
    logic       load;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        code_d   = code_q;
        valid_d  = valid_q;
        set_term = q & {4{En}};

        if (p_q[3])      top_idx = 2'd3;
        else if (p_q[2]) top_idx = 2'd2;
        else if (p_q[1]) top_idx = 2'd1;
        else             top_idx = 2'd0;

        // A new code is taken from the registered P only, when the output slot is free.
        load     = (|p_q) && ((state_q == IDLE) || ready);
        clr_term = load ? (4'b0001 << top_idx) : 4'b0000;

        // Set wins over clear; a request on an already-pending bit is merged and flagged.
        p_d        = (p_q & ~clr_term) | set_term;
        overflow_d = |(set_term & p_q & ~clr_term);

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (load) begin
                    code_d  = top_idx;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (load) begin
                        code_d  = top_idx;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            p_q        <= 4'b0000;
            code_q     <= 2'b00;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign W0       = code_q[0];
    assign W1       = code_q[1];
    assign valid    = valid_q;
    assign pending  = p_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_encoder4_to2_queue.sv
// Directed self-checking bench for encoder4_to2_queue with hand-computed expectations.
module tb_encoder4_to2_queue;

    logic       clk = 1'b0;
    logic       rst;
    logic       En;
    logic [3:0] q;
    logic       ready;
    logic       W0, W1, valid, overflow;
    logic [3:0] pending;

    int checks   = 0;
    int failures = 0;

    encoder4_to2_queue dut (
        .clk      (clk),
        .rst      (rst),
        .En       (En),
        .q        (q),
        .ready    (ready),
        .W0       (W0),
        .W1       (W1),
        .valid    (valid),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference 2-to-4 decoder.
    function automatic logic [3:0] decode(input logic w1, input logic w0, input logic en);
        logic [1:0] idx;
        idx = {w1, w0};
        return en ? (4'b0001 << idx) : 4'b0000;
    endfunction

    // Checks valid, code and pending together.
    task automatic check_out(input string tag, input logic v, input logic [1:0] code,
                             input logic [3:0] pend);
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
        if (v) check({tag, ".code"}, {6'd0, W1, W0}, {6'd0, code});
        check({tag, ".pending"}, {4'd0, pending}, {4'd0, pend});
    endtask

    initial begin
        // Reset with requests present
        rst = 1'b1; En = 1'b1; q = 4'b1111; ready = 1'b0;
        step(); step();
        rst = 1'b0; q = 4'b0000;
        check("rst.valid", {7'd0, valid}, 8'd0);
        check("rst.code", {6'd0, W1, W0}, 8'd0);
        check("rst.pending", {4'd0, pending}, 8'd0);
        check("rst.overflow", {7'd0, overflow}, 8'd0);
        step();
        check_out("rst.discard", 1'b0, 2'b00, 4'b0000);

        // Single request
        ready = 1'b1; q = 4'b0100;
        step(); q = 4'b0000;
        check_out("single.e1", 1'b0, 2'b00, 4'b0100);
        step();
        check_out("single.e2", 1'b1, 2'b10, 4'b0000);
        check("single.decode", {4'd0, decode(W1, W0, 1'b1)}, 8'b0000_0100);
        step();
        check_out("single.e3", 1'b0, 2'b00, 4'b0000);

        // Priority, back-to-back
        q = 4'b1011;
        step(); q = 4'b0000;
        check_out("prio.cap", 1'b0, 2'b00, 4'b1011);
        step(); check_out("prio.c0", 1'b1, 2'b11, 4'b0011);
        step(); check_out("prio.c1", 1'b1, 2'b01, 4'b0001);
        step(); check_out("prio.c2", 1'b1, 2'b00, 4'b0000);
        step(); check_out("prio.done", 1'b0, 2'b00, 4'b0000);

        // Backpressure
        ready = 1'b0; q = 4'b0010;
        step(); q = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step(); check_out("bp.hold", 1'b1, 2'b01, 4'b0000);
        end
        q = 4'b1000;
        step(); q = 4'b0000;
        check_out("bp.newreq", 1'b1, 2'b01, 4'b1000);
        ready = 1'b1;
        step(); ready = 1'b0;
        check_out("bp.next", 1'b1, 2'b11, 4'b0000);
        step(); check_out("bp.stall", 1'b1, 2'b11, 4'b0000);
        ready = 1'b1;
        step(); check_out("bp.drain", 1'b0, 2'b00, 4'b0000);

        // Enable blocks capture
        En = 1'b0; q = 4'b1111;
        step(); check_out("en.off", 1'b0, 2'b00, 4'b0000);
        step(); check_out("en.off2", 1'b0, 2'b00, 4'b0000);
        En = 1'b1; q = 4'b0000;

        // Overflow: duplicate request on a bit pending behind a stalled code
        ready = 1'b0; q = 4'b0010;
        step(); q = 4'b0000;
        step(); check_out("ovf.busy", 1'b1, 2'b01, 4'b0000);
        q = 4'b0001;
        step();
        check_out("ovf.first", 1'b1, 2'b01, 4'b0001);
        check("ovf.first.flag", {7'd0, overflow}, 8'd0);
        step(); q = 4'b0000;
        check_out("ovf.dup", 1'b1, 2'b01, 4'b0001);
        check("ovf.dup.flag", {7'd0, overflow}, 8'd1);
        step();
        check("ovf.clear.flag", {7'd0, overflow}, 8'd0);
        ready = 1'b1;
        step(); check_out("ovf.emit", 1'b1, 2'b00, 4'b0000);
        step(); check_out("ovf.once", 1'b0, 2'b00, 4'b0000);
        step(); check_out("ovf.once2", 1'b0, 2'b00, 4'b0000);

        // Reset mid-operation
        ready = 1'b0; q = 4'b0001;
        step(); q = 4'b1110;
        step(); q = 4'b0000;
        check_out("midrst.pre", 1'b1, 2'b00, 4'b1110);
        rst = 1'b1;
        step(); rst = 1'b0;
        check_out("midrst.post", 1'b0, 2'b00, 4'b0000);
        check("midrst.code", {6'd0, W1, W0}, 8'd0);
        check("midrst.overflow", {7'd0, overflow}, 8'd0);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); check_out("midrst.quiet", 1'b0, 2'b00, 4'b0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder4_to2_queue.md
# encoder4_to2_queue

Sequential 4-to-2 encoder, the inverse of the 2-to-4 decoder (W0/W1/En -> q). It captures request pulses on a 4-bit one-hot/multi-hot input q into a pending register. It then emits them one at a time as a 2-bit code {W1,W0}, highest index first, under a valid/ready handshake. Feeding {W1,W0} into the decoder with En=1 reproduces the original request line.

## Interface
- No parameters; widths fixed (4 request lines, 2-bit code).
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  synchronous, active-high reset
- En  in  1  request capture enable; 0 = new q bits ignored
- q  in  4  request pulses, bit i = request for code i
- ready  in  1  downstream accepts current code this cycle
- W0  out  1  code bit 0 (registered)
- W1  out  1  code bit 1 (registered)
- valid  out  1  {W1,W0} holds a pending code (registered)
- pending  out  4  current pending register P
- overflow  out  1  one-cycle pulse: request hit an already-pending bit

## Operation
- Pending register P[3:0].
  - Set term S = q & {4{En}}.
  - Clear term C = one-hot of the code being loaded this cycle, else 0.
  - P_next = (P & ~C) | S; set wins over clear on the same bit.
- Priority: highest set index of P wins (3 > 2 > 1 > 0). Code = index: W1 = idx[1], W0 = idx[0].
- Loading uses the registered P only; q arriving this cycle is not eligible until the next cycle.
- FSM states IDLE, HOLD:
  - IDLE, P == 0: stay IDLE, valid = 0, W1/W0 hold their last value.
  - IDLE, P != 0: load code of highest bit of P, clear that bit, valid <= 1, go HOLD.
  - HOLD, ready = 0: code and valid held stable; P still accepts new requests.
  - HOLD, ready = 1, (P & ~C) != 0 at that cycle: load next highest code immediately. Back-to-back, valid stays 1, stay HOLD.
  - HOLD, ready = 1, P == 0: valid <= 0, go IDLE.
- overflow <= 1 for one cycle when any bit of S is already set in P and not being cleared this cycle. The duplicate request is merged, not queued.
- En = 0 blocks capture only; already-pending requests are still serviced.
- Reset (any state, including mid-transfer) forces:
  - P = 0000, W1 = 0, W0 = 0, valid = 0, overflow = 0, state IDLE.
  - Requests on q in the reset cycle are discarded.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Request latency: q sampled at edge n -> P bit visible after edge n -> valid/code after edge n+1 (2 edges).
- Throughput: one code per cycle while ready = 1 and P nonempty.
- Handshake: a transfer occurs on an edge with valid = 1 and ready = 1. ready is don't-care when valid = 0.
- Code stability: {W1,W0} must not change while valid = 1 and ready = 0.
- pending reflects P after the edge; a bit being emitted is already cleared from pending while its code is on W1/W0.
- overflow asserts the edge after the offending q sample, deasserts the next edge unless retriggered.

## Test plan
- Reset: rst = 1 for 2 cycles with q = 1111, En = 1 -> after release valid = 0, W1W0 = 00, pending = 0000, overflow = 0.
- Single request: ready = 1, q = 0100 for one cycle.
  - Required: pending = 0100 after 1 edge.
  - Required: valid = 1, W1W0 = 10 after 2 edges, pending = 0000; valid = 0 one cycle later.
  - Required: decoder fed W1W0 reproduces q = 0100.
- Priority/back-to-back: ready = 1, q = 1011 for one cycle.
  - Required: W1W0 = 11, 01, 00 on three consecutive cycles with valid high throughout, then valid = 0.
- Backpressure: ready = 0, q = 0010 pulse.
  - Required: valid = 1, W1W0 = 01 held for 5 cycles.
  - Required: q = 1000 pulse during the hold leaves code at 01, pending = 1000.
  - Required: ready = 1 for one cycle -> next code 11 loaded, valid stays 1.
- Enable/overflow:
  - En = 0, q = 1111 -> pending stays 0000, valid stays 0.
  - En = 1, ready = 0, q = 0001 then q = 0001 again while bit 0 pending -> overflow pulses 1 cycle, only one code 00 emitted.
- Reset mid-operation: pending = 1110 with valid = 1, assert rst one cycle -> valid = 0, pending = 0000, W1W0 = 00 next edge; no codes emitted afterwards.
